// File: rtl/float_adder_if.sv
// float_adder_if
// Start/done request bus between a controlling FSM and the float_adder.
//   Start_Sig : master -> slave, operation request
//   A, B      : master -> slave, binary32 operands
//   Result    : slave -> master, registered binary32 sum
//   Done_Sig  : slave -> master, {invalid, underflow, overflow, done pulse}
interface float_adder_if;
    logic        Start_Sig;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Result;
    logic [3:0]  Done_Sig;

    modport master (output Start_Sig, A, B, input Result, Done_Sig);
    modport slave  (input Start_Sig, A, B, output Result, Done_Sig);
endinterface

// File: rtl/float_adder.sv
// float_adder
// Multi-cycle IEEE-754 binary32 adder, round-to-nearest-even.
// Stages: capture/unpack (IDLE) -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> WAIT.
// Done_Sig[0] pulses for one cycle on the 5th rising edge after the capture edge,
// together with Result and the status flags Done_Sig[3:1].
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : float_adder_if.slave (Start_Sig, A, B in; Result, Done_Sig out)
// Optional feature macro: FLUSH_TO_ZERO_EN
//   defined   : subnormal inputs read as signed zero, subnormal results are
//               flushed to signed zero (underflow flag still raised)
//   undefined : gradual underflow
module float_adder (
    input  logic         clk,
    input  logic         rst_n,
    float_adder_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ALIGN, ST_ADD, ST_NORM, ST_ROUND, ST_DONE, ST_WAIT
    } state_t;

    state_t state_q, state_d;

    // captured operands, unpacked
    logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [7:0]  exp_a_q, exp_a_d, exp_b_q, exp_b_d;
    logic [23:0] man_a_q, man_a_d, man_b_q, man_b_d;
    logic        special_q, special_d, invalid_q, invalid_d;
    logic [31:0] special_res_q, special_res_d;
    // aligned operands
    logic        sign_l_q, sign_l_d, sub_q, sub_d;
    logic [7:0]  exp_l_q, exp_l_d;
    logic [23:0] man_l_q, man_l_d;
    logic [26:0] small_q, small_d;
    // sum: [27] carry, [26:3] significand, [2] guard, [1] round, [0] sticky
    logic [27:0] sum_q, sum_d;
    logic [26:0] norm_q, norm_d;
    logic [9:0]  exp_n_q, exp_n_d;
    logic [31:0] rres_q, rres_d;
    logic [2:0]  rflags_q, rflags_d;
    logic [31:0] result_q, result_d;
    logic [3:0]  done_q, done_d;

    // Unpack and classify the live bus operands; only consumed on the capture edge.
    logic [7:0]  a_exp, b_exp;
    logic        a_nan, b_nan, a_inf, b_inf;
    logic [23:0] a_man, b_man;
    logic [7:0]  a_eexp, b_eexp;

    assign a_exp  = bus.A[30:23];
    assign b_exp  = bus.B[30:23];
    assign a_nan  = (&a_exp) & (|bus.A[22:0]);
    assign b_nan  = (&b_exp) & (|bus.B[22:0]);
    assign a_inf  = (&a_exp) & ~(|bus.A[22:0]);
    assign b_inf  = (&b_exp) & ~(|bus.B[22:0]);
    // a zero exponent field behaves as exponent 1 with no hidden bit
    assign a_eexp = (a_exp == 8'd0) ? 8'd1 : a_exp;
    assign b_eexp = (b_exp == 8'd0) ? 8'd1 : b_exp;
`ifdef FLUSH_TO_ZERO_EN
    assign a_man  = (a_exp == 8'd0) ? 24'd0 : {1'b1, bus.A[22:0]};
    assign b_man  = (b_exp == 8'd0) ? 24'd0 : {1'b1, bus.B[22:0]};
`else
    assign a_man  = {a_exp != 8'd0, bus.A[22:0]};
    assign b_man  = {b_exp != 8'd0, bus.B[22:0]};
`endif

    // Special operands are resolved up front; the result then rides through the
    // remaining stages so the latency is identical to the arithmetic path.
    logic        spec_hit, spec_inv;
    logic [31:0] spec_res;

    always_comb begin
        spec_hit = a_nan | b_nan | a_inf | b_inf;
        spec_inv = a_nan | b_nan | (a_inf & b_inf & (bus.A[31] ^ bus.B[31]));
        if (spec_inv)
            spec_res = 32'h7FC0_0000;
        else if (a_inf)
            spec_res = bus.A;
        else
            spec_res = bus.B;
    end

    // Alignment: order by magnitude, then shift the smaller significand right,
    // keeping guard/round and collapsing everything below into sticky.
    logic        a_big;
    logic [7:0]  exp_big, exp_sml, align_diff;
    logic [23:0] man_big, man_sml;
    logic [49:0] align_shifted;
    logic [26:0] align_small;

    always_comb begin
        a_big         = {exp_a_q, man_a_q} >= {exp_b_q, man_b_q};
        exp_big       = a_big ? exp_a_q : exp_b_q;
        exp_sml       = a_big ? exp_b_q : exp_a_q;
        man_big       = a_big ? man_a_q : man_b_q;
        man_sml       = a_big ? man_b_q : man_a_q;
        align_diff    = exp_big - exp_sml;
        align_shifted = {man_sml, 26'd0} >> align_diff;
        if (align_diff >= 8'd26)
            align_small = {26'd0, |man_sml};
        else
            align_small = {align_shifted[49:24], |align_shifted[23:0]};
    end

    // Normalization: a carry shifts right once; otherwise shift left by the
    // leading-zero count, clamped so the exponent never drops below 1.
    logic [9:0]  lz, max_sh, norm_sh;
    logic [26:0] norm_val;
    logic [9:0]  norm_exp;

    always_comb begin
        lz = 10'd27;
        for (int i = 0; i <= 26; i++) begin
            if (sum_q[i])
                lz = 10'(26 - i);
        end
        max_sh  = {2'b00, exp_l_q} - 10'd1;
        norm_sh = (lz < max_sh) ? lz : max_sh;
        if (sum_q[27]) begin
            norm_val = {sum_q[27:2], sum_q[1] | sum_q[0]};
            norm_exp = {2'b00, exp_l_q} + 10'd1;
        end else begin
            norm_val = sum_q[26:0] << norm_sh;
            norm_exp = {2'b00, exp_l_q} - norm_sh;
        end
    end

    // Round to nearest even and pack; a clear hidden bit means a subnormal
    // (encoded exponent 0) since normalization stopped at exponent 1.
    logic        rnd_inc;
    logic [24:0] rnd_sum;
    logic [23:0] mant_r;
    logic [9:0]  exp_r;
    logic [31:0] rnd_res;
    logic [2:0]  rnd_flags;

    always_comb begin
        rnd_inc = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
        rnd_sum = {1'b0, norm_q[26:3]} + {24'd0, rnd_inc};
        if (rnd_sum[24]) begin
            mant_r = rnd_sum[24:1];
            exp_r  = exp_n_q + 10'd1;
        end else begin
            mant_r = rnd_sum[23:0];
            exp_r  = exp_n_q;
        end
        rnd_flags = 3'b000;
        if (special_q) begin
            rnd_res   = special_res_q;
            rnd_flags = {invalid_q, 2'b00};
        end else if (norm_q == 27'd0) begin
            // exact zero is -0 only when both addends were negative
            rnd_res = {sign_a_q & sign_b_q, 31'd0};
        end else if (mant_r[23] && (exp_r >= 10'd255)) begin
            rnd_res   = {sign_l_q, 8'hFF, 23'd0};
            rnd_flags = 3'b001;
        end else if (!mant_r[23]) begin
            rnd_flags = {1'b0, |mant_r[22:0], 1'b0};
`ifdef FLUSH_TO_ZERO_EN
            rnd_res   = {sign_l_q, 31'd0};
`else
            rnd_res   = {sign_l_q, 8'd0, mant_r[22:0]};
`endif
        end else begin
            rnd_res = {sign_l_q, exp_r[7:0], mant_r[22:0]};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; WAIT blocks a held Start_Sig from retriggering.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.Start_Sig) state_d = ST_ALIGN;
            ST_ALIGN: state_d = ST_ADD;
            ST_ADD:   state_d = ST_NORM;
            ST_NORM:  state_d = ST_ROUND;
            ST_ROUND: state_d = ST_DONE;
            ST_DONE:  state_d = ST_WAIT;
            ST_WAIT:  if (!bus.Start_Sig) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Per-state datapath register loads; everything holds unless its stage runs.
    always_comb begin
        sign_a_d      = sign_a_q;
        sign_b_d      = sign_b_q;
        exp_a_d       = exp_a_q;
        exp_b_d       = exp_b_q;
        man_a_d       = man_a_q;
        man_b_d       = man_b_q;
        special_d     = special_q;
        invalid_d     = invalid_q;
        special_res_d = special_res_q;
        sign_l_d      = sign_l_q;
        sub_d         = sub_q;
        exp_l_d       = exp_l_q;
        man_l_d       = man_l_q;
        small_d       = small_q;
        sum_d         = sum_q;
        norm_d        = norm_q;
        exp_n_d       = exp_n_q;
        rres_d        = rres_q;
        rflags_d      = rflags_q;
        result_d      = result_q;
        done_d        = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (bus.Start_Sig) begin
                    sign_a_d      = bus.A[31];
                    sign_b_d      = bus.B[31];
                    exp_a_d       = a_eexp;
                    exp_b_d       = b_eexp;
                    man_a_d       = a_man;
                    man_b_d       = b_man;
                    special_d     = spec_hit;
                    invalid_d     = spec_inv;
                    special_res_d = spec_res;
                end
            end
            ST_ALIGN: begin
                sign_l_d = a_big ? sign_a_q : sign_b_q;
                sub_d    = sign_a_q ^ sign_b_q;
                exp_l_d  = exp_big;
                man_l_d  = man_big;
                small_d  = align_small;
            end
            ST_ADD: begin
                if (sub_q)
                    sum_d = {1'b0, man_l_q, 3'b000} - {1'b0, small_q};
                else
                    sum_d = {1'b0, man_l_q, 3'b000} + {1'b0, small_q};
            end
            ST_NORM: begin
                norm_d  = norm_val;
                exp_n_d = norm_exp;
            end
            ST_ROUND: begin
                rres_d   = rnd_res;
                rflags_d = rnd_flags;
            end
            ST_DONE: begin
                result_d = rres_q;
                done_d   = {rflags_q, 1'b1};
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_a_q      <= 1'b0;
            sign_b_q      <= 1'b0;
            exp_a_q       <= '0;
            exp_b_q       <= '0;
            man_a_q       <= '0;
            man_b_q       <= '0;
            special_q     <= 1'b0;
            invalid_q     <= 1'b0;
            special_res_q <= '0;
            sign_l_q      <= 1'b0;
            sub_q         <= 1'b0;
            exp_l_q       <= '0;
            man_l_q       <= '0;
            small_q       <= '0;
            sum_q         <= '0;
            norm_q        <= '0;
            exp_n_q       <= '0;
            rres_q        <= '0;
            rflags_q      <= '0;
            result_q      <= '0;
            done_q        <= '0;
        end else begin
            sign_a_q      <= sign_a_d;
            sign_b_q      <= sign_b_d;
            exp_a_q       <= exp_a_d;
            exp_b_q       <= exp_b_d;
            man_a_q       <= man_a_d;
            man_b_q       <= man_b_d;
            special_q     <= special_d;
            invalid_q     <= invalid_d;
            special_res_q <= special_res_d;
            sign_l_q      <= sign_l_d;
            sub_q         <= sub_d;
            exp_l_q       <= exp_l_d;
            man_l_q       <= man_l_d;
            small_q       <= small_d;
            sum_q         <= sum_d;
            norm_q        <= norm_d;
            exp_n_q       <= exp_n_d;
            rres_q        <= rres_d;
            rflags_q      <= rflags_d;
            result_q      <= result_d;
            done_q        <= done_d;
        end
    end

    assign bus.Result   = result_q;
    assign bus.Done_Sig = done_q;

endmodule

// File: tb/tb_float_adder.sv
// tb_float_adder
// Self-checking bench for float_adder: directed vectors, randomized operands
// compared against an exact-arithmetic reference model, and handshake/reset
// behaviour. Honors FLUSH_TO_ZERO_EN when defined.
module tb_float_adder;

    logic clk = 1'b0;
    logic rst_n;

    float_adder_if bus();

    float_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int check_count = 0;
    int pass_count  = 0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed === expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: got %08h, expected %08h", tag, observed, expected);
    endtask

    // Reference: both operands become exact integers in units of 2^-149, are
    // added exactly, and the sum is rounded once to binary32 (nearest even).
    function automatic void refModel(input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic [3:0] f);
        logic [7:0]   ea, eb;
        logic [23:0]  ma, mb;
        logic [279:0] va, vb, n, rem, half;
        logic         sign, a_nan, b_nan, a_inf, b_inf;
        logic [24:0]  m;
        int           p, sh, e, sha, shb;
        ea    = a[30:23];
        eb    = b[30:23];
        a_nan = (ea == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (eb == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (ea == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (eb == 8'hFF) && (b[22:0] == 23'd0);
        f = 4'b0001;
        r = 32'd0;
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
            r = 32'h7FC0_0000;
            f = 4'b1001;
            return;
        end
        if (a_inf) begin r = a; return; end
        if (b_inf) begin r = b; return; end
        ma = (ea == 8'd0) ? {1'b0, a[22:0]} : {1'b1, a[22:0]};
        mb = (eb == 8'd0) ? {1'b0, b[22:0]} : {1'b1, b[22:0]};
`ifdef FLUSH_TO_ZERO_EN
        if (ea == 8'd0) ma = 24'd0;
        if (eb == 8'd0) mb = 24'd0;
`endif
        sha = (ea == 8'd0) ? 0 : int'(ea) - 1;
        shb = (eb == 8'd0) ? 0 : int'(eb) - 1;
        va  = 280'(ma) << sha;
        vb  = 280'(mb) << shb;
        if (a[31] == b[31]) begin
            n = va + vb; sign = a[31];
        end else if (va >= vb) begin
            n = va - vb; sign = a[31];
        end else begin
            n = vb - va; sign = b[31];
        end
        if (n == 280'd0) begin
            r = {a[31] & b[31], 31'd0};
            return;
        end
        p = 0;
        for (int i = 0; i < 280; i++)
            if (n[i]) p = i;
        if (p <= 23) begin
            r = {sign, n[30:0]};
        end else begin
            sh   = p - 23;
            m    = 25'(n >> sh);
            rem  = n & ((280'(1) << sh) - 280'(1));
            half = 280'(1) << (sh - 1);
            if ((rem > half) || ((rem == half) && m[0]))
                m = m + 25'd1;
            if (m[24]) begin
                m  = m >> 1;
                sh = sh + 1;
            end
            e = sh + 1;
            if (e >= 255) begin
                r = {sign, 8'hFF, 23'd0};
                f = 4'b0011;
                return;
            end
            r = {sign, 8'(e), m[22:0]};
        end
        if ((r[30:23] == 8'd0) && (r[22:0] != 23'd0)) begin
            f = 4'b0101;
`ifdef FLUSH_TO_ZERO_EN
            r = {sign, 31'd0};
`endif
        end
    endfunction

    // One full operation: request, scramble operands after capture, wait for
    // the done pulse (bounded), then check latency, result, flags and hold.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input string tag);
        logic [31:0] exp_r;
        logic [3:0]  exp_f;
        int          cyc;
        refModel(a, b, exp_r, exp_f);
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        bus.Start_Sig = 1'b1;
        @(posedge clk);
        #1;
        bus.A = $urandom;
        bus.B = $urandom;
        bus.Start_Sig = 1'b0;
        cyc = 0;
        while (cyc < 12) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.Done_Sig[0]) break;
        end
        checkOutput({tag, " latency"}, 32'(cyc), 32'd5);
        checkOutput({tag, " result"}, bus.Result, exp_r);
        checkOutput({tag, " flags"}, 32'(bus.Done_Sig), 32'(exp_f));
        @(posedge clk);
        #1;
        checkOutput({tag, " done low"}, 32'(bus.Done_Sig), 32'd0);
        checkOutput({tag, " hold"}, bus.Result, exp_r);
    endtask

    logic [31:0] ra, rb, exp_r;
    logic [3:0]  exp_f;
    int          pulses;

    initial begin
        rst_n         = 1'b0;
        bus.Start_Sig = 1'b0;
        bus.A         = 32'd0;
        bus.B         = 32'd0;
        #12;
        checkOutput("reset result", bus.Result, 32'd0);
        checkOutput("reset done", 32'(bus.Done_Sig), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(32'h4069999A, 32'hC0ECCCCD, "mixed sign");
        applyStimulus(32'h00285A2D, 32'h80085847, "subnormal");
        applyStimulus(32'h3FFFFFFE, 32'hBFFFFFFF, "cancel");
        applyStimulus(32'h7FFFFFFF, 32'h7FFFFFFF, "nan");
        applyStimulus(32'h7F7FFFFF, 32'h7F7FFFFF, "overflow");
        applyStimulus(32'hC148ED91, 32'hC0E9E354, "tie even");
        applyStimulus(32'h42DF8D6A, 32'h4397386F, "round up");
        applyStimulus(32'h45040338, 32'hC4FA4670, "sub round");
        applyStimulus(32'h7F800000, 32'hFF800000, "inf minus inf");
        applyStimulus(32'hFF800000, 32'h3F800000, "inf plus finite");
        applyStimulus(32'h3F800000, 32'hBF800000, "x minus x");
        applyStimulus(32'h80000000, 32'h80000000, "neg zeros");
        applyStimulus(32'h3F800000, 32'h33800000, "tiny shift");
        applyStimulus(32'h007FFFFF, 32'h00000001, "sub to normal");

        // Random operands, biased toward close exponents, subnormals and cancellation.
        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: ;
                1: rb[30:23] = ra[30:23] + 8'($urandom_range(0, 6)) - 8'd3;
                2: begin
                    ra[30:23] = 8'd0;
                    rb[30:23] = 8'($urandom_range(0, 1));
                end
                default: begin
                    rb = ra ^ 32'h8000_0000;
                    rb[3:0] = 4'($urandom);
                end
            endcase
            applyStimulus(ra, rb, $sformatf("rand%0d", i));
        end

        // Held request: exactly one done pulse, no restart while still high.
        refModel(32'h4069999A, 32'hC0ECCCCD, exp_r, exp_f);
        @(negedge clk);
        bus.A = 32'h4069999A;
        bus.B = 32'hC0ECCCCD;
        bus.Start_Sig = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.Done_Sig[0]) pulses++;
        end
        checkOutput("held start pulses", 32'(pulses), 32'd1);
        checkOutput("held start result", bus.Result, exp_r);
        @(negedge clk);
        bus.Start_Sig = 1'b0;
        @(negedge clk);

        // Reset in the middle of an operation clears outputs at once.
        @(negedge clk);
        bus.A = 32'h42DF8D6A;
        bus.B = 32'h4397386F;
        bus.Start_Sig = 1'b1;
        @(posedge clk);
        #1;
        bus.Start_Sig = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midop reset result", bus.Result, 32'd0);
        checkOutput("midop reset done", 32'(bus.Done_Sig), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(32'h45040338, 32'hC4FA4670, "after reset");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
